rr_arb_mux_4_1: RTL and testbench
=================================

Name: rr_arb_mux_4_1

Overview:
- Upstream stage for the team's 4:1 data muxes: a 4-channel round-robin arbiter.
- Arbitrates between four valid/ready producers and generates the 2-bit select.
- Steers the granted channel's data through a narrow-mux datapath into a single registered valid/ready output slice.
- Sustains one transfer per cycle; grants are fair among active requesters.

Parameters:
- W, 4, data width per channel; must be even and ≥ 2. Datapath is W/2 instances of the existing 2-bit 4:1 mux cell (mux_4_1_width_2), all sharing the grant index as select.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- up_valid  input  4  per-channel request/valid
- up_data0  input  W  channel 0 data
- up_data1  input  W  channel 1 data
- up_data2  input  W  channel 2 data
- up_data3  input  W  channel 3 data
- up_ready  output  4  per-channel ready, one-hot or zero
- down_valid  output  1  output register holds a transfer
- down_data  output  W  registered selected data
- down_chan  output  2  registered index of the channel that supplied down_data
- down_ready  input  1  downstream accepts

Behaviour:
- Reset (rst=1 at clk edge):
  - down_valid=0, down_data=0, down_chan=0.
  - last-grant pointer = 3, so channel 0 has top priority first.
  - Reset mid-transfer discards the held word; no partial state survives.
- accept = !down_valid || down_ready (combinational).
- Grant index g (combinational): first i with up_valid[i]=1, scanning (last+1)%4, (last+2)%4, (last+3)%4, last.
- up_ready:
  - up_ready[g]=1 only when accept=1 and |up_valid=1; all other bits 0.
  - Never more than one bit set.
  - Depends combinationally on up_valid and state; producers must not make up_valid depend on up_ready.
- On clk edge, accept=1 and |up_valid=1: down_data<=selected data (via mux cells, sel=g), down_chan<=g, down_valid<=1, last<=g.
- On clk edge, accept=1 and up_valid=0: down_valid<=0; down_data, down_chan, last unchanged.
- On clk edge, accept=0 (stall): all registers hold; up_ready=0.
- Latency 1 cycle, upstream handshake to down_valid. Throughput 1 word/cycle with down_ready held high.
- Fairness: with all four channels continuously valid, grant order is 0,1,2,3,0,...; no channel waits more than 3 transfers.
- Pointer wrap: last=3 → scan starts at 0.
- Simultaneous down_ready=1 and new grant in the same cycle: old word retires and new word loads in the same edge, no bubble.
- A channel whose up_valid drops while not granted loses nothing; the pointer only moves on a completed grant.
- Output stability: while down_valid=1 and down_ready=0, down_data and down_chan are stable.

Optional Feature:
- Macro: RR_ARB_MUX_XFER_COUNT_EN
- Defined: adds output port xfer_count (16 bits).
  - Increments by 1 on each edge where down_valid && down_ready.
  - Wraps 16'hFFFF→0.
  - Reset to 0 by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then idle: rst high 2 cycles, all up_valid=0 → down_valid=0, down_data=0, down_chan=0, up_ready=4'b0000.
- Single channel: up_valid=4'b0100, up_data2=4'hA, down_ready=1 → up_ready=4'b0100 same cycle; next cycle down_valid=1, down_data=4'hA, down_chan=2.
- All valid, down_ready=1 for 8 cycles, up_dataN=N+5 → down_chan sequence 0,1,2,3,0,1,2,3 with data 5,6,7,8,...; down_valid continuous.
- Backpressure: transfer ch1 (data 4'h3) loaded, then down_ready=0 for 3 cycles with up_valid=4'b1111 → up_ready=0, down_data stays 4'h3 / down_chan 1. Release → next grant is ch2.
- Reset mid-stream: down_valid=1 holding ch3, assert rst → next cycle down_valid=0. With up_valid=4'b1001 after reset, first grant is ch0, not ch3.
- With RR_ARB_MUX_XFER_COUNT_EN: 70000 back-to-back transfers → xfer_count = 70000 mod 65536 = 4464; without the macro the port does not exist (compile check).

Source files
------------

// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter that feeds one registered valid/ready output slice.
// The datapath uses W/2 copies of mux_4_1_width_2. Define RR_ARB_MUX_XFER_COUNT_EN to add the xfer_count output.

module mux_4_1_width_2 (
    input  logic [1:0] i_d0,
    input  logic [1:0] i_d1,
    input  logic [1:0] i_d2,
    input  logic [1:0] i_d3,
    input  logic [1:0] i_sel,
    output logic [1:0] o_y
);
    always_comb begin
        unique case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end
endmodule

module rr_arb_mux_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   up_valid,
    input  logic [W-1:0] up_data0,
    input  logic [W-1:0] up_data1,
    input  logic [W-1:0] up_data2,
    input  logic [W-1:0] up_data3,
    output logic [3:0]   up_ready,
    output logic         down_valid,
    output logic [W-1:0] down_data,
    output logic [1:0]   down_chan,
    input  logic         down_ready
`ifdef RR_ARB_MUX_XFER_COUNT_EN
    ,
    output logic [15:0]  xfer_count
`endif
);
    localparam int NCELL = W / 2;

    logic [1:0]   r_last;
    logic         r_valid;
    logic [W-1:0] r_data;
    logic [1:0]   r_chan;

    logic         w_accept;
    logic         w_any;
    logic [1:0]   w_grant;
    logic [W-1:0] w_mux_data;

    assign w_accept = !r_valid || down_ready;
    assign w_any    = |up_valid;

    // Scan starts one past the last grant, so the previous winner is checked last.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found   = 1'b0;
        idx     = '0;
        w_grant = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!found && up_valid[idx]) begin
                w_grant = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        up_ready = '0;
        if (w_accept && w_any) begin
            up_ready[w_grant] = 1'b1;
        end
    end

    for (genvar c = 0; c < NCELL; c++) begin : g_mux
        mux_4_1_width_2 u_mux (
            .i_d0  (up_data0[2*c+1:2*c]),
            .i_d1  (up_data1[2*c+1:2*c]),
            .i_d2  (up_data2[2*c+1:2*c]),
            .i_d3  (up_data3[2*c+1:2*c]),
            .i_sel (w_grant),
            .o_y   (w_mux_data[2*c+1:2*c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_last  <= 2'd3;
        end else if (w_accept) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_mux_data;
                r_chan  <= w_grant;
                r_last  <= w_grant;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign down_valid = r_valid;
    assign down_data  = r_data;
    assign down_chan  = r_chan;

`ifdef RR_ARB_MUX_XFER_COUNT_EN
    logic [15:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (r_valid && down_ready) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Self-checking bench for rr_arb_mux_4_1 that compares the DUT against a behavioural round-robin model.
// Define RR_ARB_MUX_XFER_COUNT_EN to also exercise xfer_count.

module tb_rr_arb_mux_4_1;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   up_valid;
    logic [W-1:0] up_data0, up_data1, up_data2, up_data3;
    logic [3:0]   up_ready;
    logic         down_valid;
    logic [W-1:0] down_data;
    logic [1:0]   down_chan;
    logic         down_ready;
`ifdef RR_ARB_MUX_XFER_COUNT_EN
    logic [15:0]  xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           m_last;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_cnt;

    always #5 clk = ~clk;

    rr_arb_mux_4_1 #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data0   (up_data0),
        .up_data1   (up_data1),
        .up_data2   (up_data2),
        .up_data3   (up_data3),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_chan  (down_chan),
        .down_ready (down_ready)
`ifdef RR_ARB_MUX_XFER_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    function automatic int exp_grant();
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (up_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        logic [3:0] r;
        g = exp_grant();
        r = 4'b0000;
        if ((!m_valid || down_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] chan_data(input int ch);
        case (ch)
            0: return up_data0;
            1: return up_data1;
            2: return up_data2;
            default: return up_data3;
        endcase
    endfunction

    // Wait for one rising edge, advance the model with the inputs seen at that edge, then move 1 time unit past the edge.
    task automatic tick();
        int g;
        @(posedge clk);
        g = exp_grant();
        if (rst) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_last = 3; m_cnt = 0;
        end else begin
            if (m_valid && down_ready) m_cnt = (m_cnt + 1) % 65536;
            if (!m_valid || down_ready) begin
                if (g >= 0) begin
                    m_valid = 1; m_data = chan_data(g); m_chan = g; m_last = g;
                end else begin
                    m_valid = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; up_valid = 4'b0000; down_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        up_data0 = '0; up_data1 = '0; up_data2 = '0; up_data3 = '0;
        do_reset();
        #1;
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", down_valid); end
        checks++; if (down_data !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", down_data); end
        checks++; if (down_chan !== 2'd0) begin errors++; $display("FAIL reset_chan got %0d expected 0", down_chan); end
        checks++; if (up_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b expected 0000", up_ready); end
    endtask

    task automatic test_single();
        do_reset();
        up_valid = 4'b0100; up_data2 = 4'hA; down_ready = 1'b1;
        #1;
        checks++; if (up_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b expected 0100", up_ready); end
        tick();
        checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b expected 1", down_valid); end
        checks++; if (down_data !== 4'hA) begin errors++; $display("FAIL single_data got %h expected a", down_data); end
        checks++; if (down_chan !== 2'd2) begin errors++; $display("FAIL single_chan got %0d expected 2", down_chan); end
        up_valid = 4'b0000;
        tick();
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b expected 0", down_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        up_data0 = 4'd5; up_data1 = 4'd6; up_data2 = 4'd7; up_data3 = 4'd8;
        up_valid = 4'b1111; down_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b expected 1", i, down_valid); end
            checks++; if (down_chan !== 2'(i % 4)) begin errors++; $display("FAIL b2b_chan[%0d] got %0d expected %0d", i, down_chan, i % 4); end
            checks++; if (down_data !== 4'(i % 4 + 5)) begin errors++; $display("FAIL b2b_data[%0d] got %0d expected %0d", i, down_data, i % 4 + 5); end
        end
        up_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        up_valid = 4'b0010; up_data1 = 4'h3; down_ready = 1'b1;
        tick();
        up_valid = 4'b1111; down_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (up_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b expected 0000", i, up_ready); end
            tick();
            checks++; if (down_data !== 4'h3 || down_chan !== 2'd1 || down_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got v%b d%h c%0d expected v1 d3 c1", i, down_valid, down_data, down_chan);
            end
        end
        down_ready = 1'b1;
        #1;
        checks++; if (up_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b expected 0100", up_ready); end
        tick();
        checks++; if (down_chan !== 2'd2) begin errors++; $display("FAIL bp_release_chan got %0d expected 2", down_chan); end
        up_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        up_valid = 4'b1000; up_data3 = 4'hC; down_ready = 1'b1;
        tick();
        down_ready = 1'b0; up_valid = 4'b0000;
        checks++; if (down_valid !== 1'b1 || down_chan !== 2'd3) begin
            errors++; $display("FAIL mid_hold got v%b c%0d expected v1 c3", down_valid, down_chan);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b expected 0", down_valid); end
        up_valid = 4'b1001; down_ready = 1'b1;
        #1;
        checks++; if (up_ready !== 4'b0001) begin errors++; $display("FAIL mid_ready got %b expected 0001", up_ready); end
        tick();
        checks++; if (down_chan !== 2'd0) begin errors++; $display("FAIL mid_first_chan got %0d expected 0", down_chan); end
        up_valid = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            up_valid   = 4'($urandom);
            up_data0   = W'($urandom); up_data1 = W'($urandom);
            up_data2   = W'($urandom); up_data3 = W'($urandom);
            down_ready = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 63) == 0);
            #1;
            if (!rst) begin
                checks++; if (up_ready !== exp_ready()) begin
                    errors++; $display("FAIL rand_ready[%0d] got %b expected %b", i, up_ready, exp_ready());
                end
            end
            tick();
            checks++; if (down_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got %b expected %b", i, down_valid, m_valid); end
            if (m_valid) begin
                checks++; if (down_data !== m_data || down_chan !== 2'(m_chan)) begin
                    errors++; $display("FAIL rand_word[%0d] got d%h c%0d expected d%h c%0d", i, down_data, down_chan, m_data, m_chan);
                end
            end
`ifdef RR_ARB_MUX_XFER_COUNT_EN
            checks++; if (xfer_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand_count[%0d] got %0d expected %0d", i, xfer_count, m_cnt); end
`endif
        end
        rst = 1'b0;
    endtask

`ifdef RR_ARB_MUX_XFER_COUNT_EN
    task automatic test_xfer_count();
        do_reset();
        up_valid = 4'b1111; down_ready = 1'b1;
        tick();
        for (int i = 0; i < 70000; i++) tick();
        checks++; if (xfer_count !== 16'd4464) begin errors++; $display("FAIL xfer_count got %0d expected 4464", xfer_count); end
        up_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        m_last = 3; m_valid = 0; m_data = '0; m_chan = 0; m_cnt = 0;
        rst = 1'b1; up_valid = '0; down_ready = 1'b1;
        up_data0 = '0; up_data1 = '0; up_data2 = '0; up_data3 = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef RR_ARB_MUX_XFER_COUNT_EN
        test_xfer_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
